// File: rtl/elm_hidden_neuron.sv
// One ELM hidden-layer neuron: streams features against a weight ROM, accumulates
// with saturation, adds bias, rescales, saturates and applies ReLU.
module elm_hidden_neuron #(
  parameter int layerNo      = 1,
  parameter int neuronNo     = 0,
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int fracWidth    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [dataWidth-1:0]    myinput,
  input  logic                    myinputValid,
  input  logic [dataWidth-1:0]    biasIn,
  output logic                    w_ren,
  output logic [addressWidth:0]   w_raddr,
  input  logic [dataWidth-1:0]    w_rdata,
  output logic [dataWidth-1:0]    out,
  output logic                    outvalid
);

  localparam int PW = 2 * dataWidth;
  localparam logic [addressWidth:0]    LAST = (addressWidth + 1)'(numWeight - 1);
  localparam logic signed [PW-1:0]     PMAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic signed [PW-1:0]     PMIN = {1'b1, {(PW-1){1'b0}}};
  localparam logic signed [PW-1:0]     DMAX_W = {{(PW-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
  localparam logic signed [PW-1:0]     DMIN_W = {{(PW-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};

  // layer/neuron indices only identify the instance
  logic unused_params;
  assign unused_params = ^{layerNo[0], neuronNo[0]};

  logic [addressWidth:0]         rcnt;
  logic [addressWidth:0]         pcnt;
  logic [dataWidth-1:0]          in_d;
  logic signed [PW-1:0]          prod;
  logic signed [PW-1:0]          sum;
  logic signed [PW-1:0]          fin;
  logic                          v1, v2, v3;

  logic signed [PW-1:0]          mult;
  logic signed [PW:0]            acc_ext;
  logic signed [PW-1:0]          acc_sat;
  logic signed [PW-1:0]          bias_sh;
  logic signed [PW:0]            t_ext;
  logic signed [PW-1:0]          t_sat;
  logic signed [PW-1:0]          shifted;
  logic signed [PW-1:0]          clipped;
  logic [dataWidth-1:0]          result;

  assign w_ren   = myinputValid;
  assign w_raddr = rcnt;

  always_comb begin
    mult    = PW'($signed(in_d)) * PW'($signed(w_rdata));

    acc_ext = {sum[PW-1], sum} + {prod[PW-1], prod};
    acc_sat = acc_ext[PW-1:0];
    if (acc_ext[PW] != acc_ext[PW-1])
      acc_sat = acc_ext[PW] ? PMIN : PMAX;

    // bias is a dataWidth fixed-point value; align it with the product format
    bias_sh = {{(PW-dataWidth){biasIn[dataWidth-1]}}, biasIn} <<< fracWidth;
    t_ext   = {fin[PW-1], fin} + {bias_sh[PW-1], bias_sh};
    t_sat   = t_ext[PW-1:0];
    if (t_ext[PW] != t_ext[PW-1])
      t_sat = t_ext[PW] ? PMIN : PMAX;

    shifted = t_sat >>> fracWidth;
    clipped = shifted;
    if (shifted > DMAX_W)
      clipped = DMAX_W;
    else if (shifted < DMIN_W)
      clipped = DMIN_W;

    result = clipped[PW-1] ? '0 : clipped[dataWidth-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt     <= '0;
      pcnt     <= '0;
      in_d     <= '0;
      prod     <= '0;
      sum      <= '0;
      fin      <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      out      <= '0;
      outvalid <= 1'b0;
    end else begin
      if (myinputValid)
        rcnt <= (rcnt == LAST) ? '0 : rcnt + (addressWidth + 1)'(1);

      v1 <= myinputValid;
      if (myinputValid)
        in_d <= myinput;

      v2 <= v1;
      if (v1)
        prod <= mult;

      // the vector's last product hands its total to S3 and restarts the accumulator
      v3 <= 1'b0;
      if (v2) begin
        if (pcnt == LAST) begin
          fin  <= acc_sat;
          v3   <= 1'b1;
          sum  <= '0;
          pcnt <= '0;
        end else begin
          sum  <= acc_sat;
          pcnt <= pcnt + (addressWidth + 1)'(1);
        end
      end

      outvalid <= v3;
      if (v3)
        out <= result;
    end
  end

endmodule
